// File: rtl/graph_neighbor_aggregator_pkg.sv
// Shared types and helpers for the GNN neighbour-aggregation stage.
//   agg_mode_e  : aggregation mode (SUM / MAX), encoded as the 1-bit mode port
//   agg_state_e : top-level control FSM states
//   sign_ext    : sign-extend a w-bit value held in the low bits of a CALC_W word
//   saturate    : clamp a CALC_W signed value to the signed range of a w-bit word
package gnn_agg_pkg;

    typedef enum logic {
        AGG_SUM = 1'b0,
        AGG_MAX = 1'b1
    } agg_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } agg_state_e;

    // Working width for the helpers; every datapath width must stay below it.
    localparam int unsigned CALC_W = 64;

    function automatic logic signed [CALC_W-1:0] sign_ext(
        input logic [CALC_W-1:0] v,
        input int unsigned       w
    );
        logic signed [CALC_W-1:0] t;
        t = $signed(v << (CALC_W - w));
        return t >>> (CALC_W - w);
    endfunction

    function automatic logic signed [CALC_W-1:0] saturate(
        input logic signed [CALC_W-1:0] v,
        input int unsigned              w
    );
        logic signed [CALC_W-1:0] hi;
        logic signed [CALC_W-1:0] lo;
        hi = $signed((64'd1 << (w - 1)) - 64'd1);
        lo = ~hi;
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/graph_neighbor_aggregator_agg_lane.sv
// agg_lane: one (node, feature) accumulator of the neighbour aggregator.
//   clk, rst_n : clock, asynchronous active-low reset
//   init_i     : load the start value for a new bundle (0 for SUM, most negative for MAX)
//   mode_i     : aggregation mode (0=SUM, 1=MAX)
//   upd_i      : fold x_i into the accumulator this cycle
//   fin_i      : final step; register the saturated result (including this cycle's update)
//   empty_i    : row had no contributors; result forced to 0 on fin_i
//   x_i        : signed neighbour feature (IN_W)
//   agg_o      : registered, saturated aggregate (OUT_W)
module agg_lane
    import gnn_agg_pkg::*;
#(
    parameter int unsigned IN_W  = 5,
    parameter int unsigned ACC_W = 7,
    parameter int unsigned OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             init_i,
    input  logic             mode_i,
    input  logic             upd_i,
    input  logic             fin_i,
    input  logic             empty_i,
    input  logic [IN_W-1:0]  x_i,
    output logic [OUT_W-1:0] agg_o
);

    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [ACC_W-1:0] x_ext;
    logic        [OUT_W-1:0] out_q, out_d;

    always_comb begin
        x_ext = ACC_W'(sign_ext(CALC_W'(x_i), IN_W));
        acc_d = acc_q;
        if (init_i) begin
            acc_d = (mode_i == AGG_MAX) ? ACC_MIN : '0;
        end else if (upd_i) begin
            if (mode_i == AGG_MAX) begin
                acc_d = (x_ext > acc_q) ? x_ext : acc_q;
            end else begin
                acc_d = acc_q + x_ext;
            end
        end
    end

    // The final result is taken from acc_d so the last neighbour's update
    // lands in the same cycle the output register is loaded.
    always_comb begin
        out_d = out_q;
        if (fin_i) begin
            if (empty_i) begin
                out_d = '0;
            end else begin
                out_d = OUT_W'(saturate(sign_ext(CALC_W'(acc_d), ACC_W), OUT_W));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

    assign agg_o = out_q;

endmodule

// File: rtl/graph_neighbor_aggregator.sv
// graph_neighbor_aggregator: aggregates neighbour feature vectors under a
// runtime adjacency mask, one source node per cycle, SUM or MAX mode.
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : input bundle valid          in_ready  : block can accept a bundle
//   mode       : 0=SUM, 1=MAX, sampled on accept
//   adj        : bit [i*N+j]=1 -> node j contributes to node i
//   x_flat     : node j feature f at [(j*F+f)*IN_W +: IN_W]
//   out_valid  : results valid               out_ready : downstream accepts results
//   agg_flat   : saturated aggregates, same packing as x_flat (OUT_W per entry)
//   empty_row  : bit i=1 -> node i had no contributors
module graph_neighbor_aggregator
    import gnn_agg_pkg::*;
#(
    parameter int unsigned NUM_NODES = 4,
    parameter int unsigned NUM_FEAT  = 4,
    parameter int unsigned IN_W      = 5,
    parameter int unsigned OUT_W     = 7
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic                                mode,
    input  logic [NUM_NODES*NUM_NODES-1:0]      adj,
    input  logic [NUM_NODES*NUM_FEAT*IN_W-1:0]  x_flat,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [NUM_NODES*NUM_FEAT*OUT_W-1:0] agg_flat,
    output logic [NUM_NODES-1:0]                empty_row
);

    localparam int unsigned N     = NUM_NODES;
    localparam int unsigned F     = NUM_FEAT;
    localparam int unsigned ACC_W = IN_W + $clog2(N);
    localparam int unsigned CNT_W = $clog2(N);

    agg_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [N*F*IN_W-1:0]     x_q, x_d;
    logic [N*N-1:0]          adj_q, adj_d;
    agg_mode_e               mode_q, mode_d;
    logic [N-1:0]            hit_q, hit_d;
    logic [N-1:0]            empty_q, empty_d;

    logic [F*IN_W-1:0]       cur_x;
    logic [N-1:0]            cur_adj;
    agg_mode_e               lane_mode;
    logic                    lane_init;
    logic                    lane_upd;
    logic                    lane_fin;

    // Features of the current source node j and the adjacency column for j.
    always_comb begin
        cur_x   = '0;
        cur_adj = '0;
        for (int unsigned j = 0; j < N; j++) begin
            if (cnt_q == CNT_W'(j)) begin
                cur_x = x_q[j*F*IN_W +: F*IN_W];
                for (int unsigned i = 0; i < N; i++) begin
                    cur_adj[i] = adj_q[i*N + j];
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        x_d       = x_q;
        adj_d     = adj_q;
        mode_d    = mode_q;
        hit_d     = hit_q;
        empty_d   = empty_q;
        lane_mode = mode_q;
        lane_init = 1'b0;
        lane_upd  = 1'b0;
        lane_fin  = 1'b0;
        case (state_q)
            IDLE: begin
                // Lanes initialise from the incoming mode on the accept edge.
                lane_mode = agg_mode_e'(mode);
                if (in_valid) begin
                    x_d       = x_flat;
                    adj_d     = adj;
                    mode_d    = agg_mode_e'(mode);
                    hit_d     = '0;
                    cnt_d     = '0;
                    lane_init = 1'b1;
                    state_d   = ACCUM;
                end
            end
            ACCUM: begin
                lane_upd = 1'b1;
                hit_d    = hit_q | cur_adj;
                if (cnt_q == CNT_W'(N - 1)) begin
                    lane_fin = 1'b1;
                    empty_d  = ~hit_d;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            adj_q   <= '0;
            mode_q  <= AGG_SUM;
            hit_q   <= '0;
            empty_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            adj_q   <= adj_d;
            mode_q  <= mode_d;
            hit_q   <= hit_d;
            empty_q <= empty_d;
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_node
        for (genvar gf = 0; gf < F; gf++) begin : g_feat
            agg_lane #(
                .IN_W  (IN_W),
                .ACC_W (ACC_W),
                .OUT_W (OUT_W)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .init_i  (lane_init),
                .mode_i  (lane_mode),
                .upd_i   (lane_upd & cur_adj[gi]),
                .fin_i   (lane_fin),
                .empty_i (~hit_d[gi]),
                .x_i     (cur_x[gf*IN_W +: IN_W]),
                .agg_o   (agg_flat[(gi*F+gf)*OUT_W +: OUT_W])
            );
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign empty_row = empty_q;

endmodule

// File: tb/tb_graph_neighbor_aggregator.sv
module tb_graph_neighbor_aggregator;

    typedef struct packed {
        logic [111:0] a7;
        logic [95:0]  a6;
        logic [3:0]   emp;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         mode;
    logic [15:0]  adj;
    logic [79:0]  x_flat;
    logic         out_ready;

    logic         in_ready, out_valid;
    logic [111:0] agg_flat;
    logic [3:0]   empty_row;
    logic         in_ready6, out_valid6;
    logic [95:0]  agg6;
    logic [3:0]   empty6;

    int   total;
    int   bad;
    int   cyc;
    int   acc_cyc;
    exp_t sb[$];

    graph_neighbor_aggregator dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mode      (mode),
        .adj       (adj),
        .x_flat    (x_flat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .agg_flat  (agg_flat),
        .empty_row (empty_row)
    );

    graph_neighbor_aggregator #(.OUT_W(6)) dut6 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready6),
        .mode      (mode),
        .adj       (adj),
        .x_flat    (x_flat),
        .out_valid (out_valid6),
        .out_ready (out_ready),
        .agg_flat  (agg6),
        .empty_row (empty6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Independent integer model: aggregate, zero empty rows, clip to 7 and 6 bits.
    function automatic exp_t model(input logic [15:0] a, input int xv[16], input logic m);
        exp_t e;
        int   acc;
        int   v;
        e = '0;
        for (int i = 0; i < 4; i++) begin
            e.emp[i] = (a[i*4 +: 4] == 4'b0000);
            for (int f = 0; f < 4; f++) begin
                acc = m ? -1000 : 0;
                for (int j = 0; j < 4; j++) begin
                    if (a[i*4+j]) begin
                        if (m) acc = (xv[j*4+f] > acc) ? xv[j*4+f] : acc;
                        else   acc = acc + xv[j*4+f];
                    end
                end
                if (e.emp[i]) acc = 0;
                v = (acc > 63) ? 63 : ((acc < -64) ? -64 : acc);
                e.a7[(i*4+f)*7 +: 7] = v[6:0];
                v = (acc > 31) ? 31 : ((acc < -32) ? -32 : acc);
                e.a6[(i*4+f)*6 +: 6] = v[5:0];
            end
        end
        return e;
    endfunction

    task automatic send(input logic [15:0] a, input int xv[16], input logic m);
        int n;
        n = 0;
        while (!in_ready && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_wait in_ready=%0b required=1", in_ready);
        end
        adj  = a;
        mode = m;
        for (int k = 0; k < 16; k++) x_flat[k*5 +: 5] = xv[k][4:0];
        in_valid = 1'b1;
        sb.push_back(model(a, xv, m));
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
        // Scramble inputs; the in-flight bundle must use latched copies.
        x_flat = 80'({$urandom(), $urandom(), $urandom()});
        adj    = 16'($urandom());
        mode   = ~mode;
    endtask

    task automatic wait_result(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (!out_valid || sb.size() == 0) begin
            bad++;
            $display("FAIL %s_timeout out_valid=%0b pending=%0d", name, out_valid, sb.size());
            return;
        end
        e = sb.pop_front();
        total++;
        if (cyc - acc_cyc != 4) begin
            bad++;
            $display("FAIL %s_latency got=%0d want=4", name, cyc - acc_cyc);
        end
        total++;
        if (agg_flat !== e.a7) begin
            bad++;
            $display("FAIL %s_agg7 got=%h want=%h", name, agg_flat, e.a7);
        end
        total++;
        if (agg6 !== e.a6) begin
            bad++;
            $display("FAIL %s_agg6 got=%h want=%h", name, agg6, e.a6);
        end
        total++;
        if (empty_row !== e.emp || empty6 !== e.emp) begin
            bad++;
            $display("FAIL %s_empty got=%b/%b want=%b", name, empty_row, empty6, e.emp);
        end
        total++;
        if (out_valid6 !== 1'b1 || in_ready !== 1'b0) begin
            bad++;
            $display("FAIL %s_hs out_valid6=%0b in_ready=%0b want 1/0", name, out_valid6, in_ready);
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_reset_vals(input string name);
        total++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || in_ready6 !== 1'b1 || out_valid6 !== 1'b0) begin
            bad++;
            $display("FAIL %s_hs in_ready=%0b out_valid=%0b want 1/0", name, in_ready, out_valid);
        end
        total++;
        if (agg_flat !== '0 || agg6 !== '0) begin
            bad++;
            $display("FAIL %s_agg got=%h/%h want=0", name, agg_flat, agg6);
        end
        total++;
        if (empty_row !== 4'b0 || empty6 !== 4'b0) begin
            bad++;
            $display("FAIL %s_empty got=%b/%b want=0", name, empty_row, empty6);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_sum_legacy();
        int xv[16];
        for (int k = 0; k < 16; k++) xv[k] = k / 4 + 1;
        send(16'hEDB7, xv, 1'b0);
        wait_result("sum_legacy");
        release_out();
    endtask

    task automatic test_max_legacy();
        int xv[16];
        int vals[4];
        vals = '{1, -3, 2, -16};
        for (int k = 0; k < 16; k++) xv[k] = vals[k/4];
        send(16'hEDB7, xv, 1'b1);
        wait_result("max_legacy");
        release_out();
    endtask

    task automatic test_saturate();
        int xv[16];
        for (int k = 0; k < 16; k++) xv[k] = 15;
        send(16'hFFFF, xv, 1'b0);
        wait_result("sat_pos");
        release_out();
        for (int k = 0; k < 16; k++) xv[k] = -16;
        send(16'hFFFF, xv, 1'b0);
        wait_result("sat_neg");
        release_out();
    endtask

    task automatic test_empty_row();
        int xv[16];
        for (int k = 0; k < 16; k++) xv[k] = int'($urandom_range(31, 0)) - 16;
        send(16'hE0B7, xv, 1'b1);
        wait_result("empty_row");
        release_out();
    endtask

    task automatic test_backpressure();
        int           xv[16];
        logic [111:0] held7;
        logic [95:0]  held6;
        for (int k = 0; k < 16; k++) xv[k] = int'($urandom_range(31, 0)) - 16;
        send(16'h9A5C, xv, 1'b0);
        wait_result("bp");
        held7 = agg_flat;
        held6 = agg6;
        for (int c = 0; c < 10; c++) begin
            x_flat   = 80'({$urandom(), $urandom(), $urandom()});
            adj      = 16'($urandom());
            in_valid = ~in_valid;
            @(posedge clk); #1;
            total++;
            if (agg_flat !== held7 || agg6 !== held6 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                bad++;
                $display("FAIL bp_hold c=%0d agg=%h in_ready=%0b out_valid=%0b want %h/0/1",
                         c, agg_flat, in_ready, out_valid, held7);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release out_valid=%0b in_ready=%0b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int xv[16];
        for (int k = 0; k < 16; k++) xv[k] = 15 - k;
        send(16'hFFFF, xv, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        sb.delete();
        check_reset_vals("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_vals("rst_after");
        for (int k = 0; k < 16; k++) xv[k] = (k % 3) - 1;
        send(16'h1248, xv, 1'b1);
        wait_result("rst_new");
        release_out();
    endtask

    task automatic test_back_to_back();
        int xv[16];
        int prev;
        out_ready = 1'b1;
        prev = -1;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 16; k++) xv[k] = int'($urandom_range(31, 0)) - 16;
            send(16'($urandom()), xv, 1'($urandom_range(1, 0)));
            if (prev >= 0) begin
                total++;
                if (acc_cyc - prev != 6) begin
                    bad++;
                    $display("FAIL b2b_gap got=%0d want=6", acc_cyc - prev);
                end
            end
            prev = acc_cyc;
            wait_result("b2b");
        end
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        cyc       = 0;
        acc_cyc   = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        mode      = 1'b0;
        adj       = '0;
        x_flat    = '0;
        out_ready = 1'b0;
        #1;
        test_reset();
        test_sum_legacy();
        test_max_legacy();
        test_saturate();
        test_empty_row();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/graph_neighbor_aggregator.md
Name: graph_neighbor_aggregator

Overview:
Parametrised successor to the fixed 4-node GNN aggregation stage. It aggregates the feature vectors of each node's neighbours under a runtime adjacency mask, for any node count and feature count. Two modes are supported: SUM and MAX. It processes one source node per cycle, saturates results to the output width, and uses valid/ready handshakes on both sides. It sits between the feature-load stage and the combination (weight-multiply) stage of the accelerator.

Parameters:
NUM_NODES, 4, graph nodes N (>=2)
NUM_FEAT, 4, features per node F (>=1)
IN_W, 5, signed input feature width
OUT_W, 7, signed output width (>=IN_W)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input bundle valid
in_ready  out  1  block can accept a bundle
mode  in  1  0=SUM, 1=MAX; sampled on accept
adj  in  N*N  bit [i*N+j]=1: node j contributes to node i (self-loop explicit)
x_flat  in  N*F*IN_W  signed features; node j feature f at [(j*F+f)*IN_W +: IN_W]
out_valid  out  1  results valid
out_ready  in  1  downstream accepts results
agg_flat  out  N*F*OUT_W  signed aggregates, same packing as x_flat
empty_row  out  N  bit i=1: node i had no contributors

Behaviour:
- Reset (async): state IDLE, in_ready=1, out_valid=0, agg_flat=0, empty_row=0, accumulators and counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch x_flat, adj and mode. Initialise accumulators: SUM -> 0; MAX -> most negative ACC value. Clear the row-hit flags. Counter j=0. Go to ACCUM.
  - ACCUM: in_ready=0. Each cycle, for all i,f in parallel, if adj[i][j]: SUM acc+=x[j][f]; MAX acc=max(acc,x[j][f]); set hit[i].
    - When j==N-1: perform the final update, register saturated results into agg_flat, set empty_row=~hit, set out_valid=1, go to DONE.
    - Otherwise j++.
  - DONE: out_valid=1, agg_flat and empty_row held stable. On out_ready, clear out_valid and go to IDLE; in_ready=1 from the next cycle.
- Latency: out_valid rises on the Nth clock edge after the accept edge.
- Throughput: one bundle per N+2 cycles minimum; bundles never overlap.
- Width rules:
  - ACC_W = IN_W+$clog2(N); all arithmetic is signed.
  - Output = ACC saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; saturation never wraps.
  - With the defaults (ACC_W=7=OUT_W), saturation is a no-op.
- Empty row (no contributors): output 0 in both modes, empty_row[i]=1.
- Latched inputs: changes on x_flat/adj/mode after accept have no effect on the in-flight bundle.
- out_ready while out_valid=0 is ignored. in_valid while in_ready=0 is ignored; upstream holds the bundle.
- rst_n asserted mid-ACCUM or mid-DONE: immediate return to reset values; the partial result is discarded and never presented.

Decomposition:
- Package gnn_agg_pkg: mode enum (AGG_SUM, AGG_MAX), state enum (IDLE, ACCUM, DONE), and saturate/sign-extend functions parametrised by width.
- One sub-module, agg_lane: a single feature accumulator (ACC_W register, SUM/MAX update, saturating output), instantiated N*F times via generate.
- FSM and counter stay in the top level.

Test Plan:
- Legacy graph (rows 0:{0,1,2}, 1:{0,1,3}, 2:{0,2,3}, 3:{1,2,3}), SUM, all features of node0..3 = 1,2,3,4 -> outputs 6,7,8,9 per feature; out_valid exactly 4 edges after accept.
- Same graph, MAX mode, node features 1,-3,2,-16 -> node0=2, node1=1, node2=2, node3=2.
- OUT_W=6 override, full adjacency, all x=15, SUM -> every output 31 (sum 60 saturated); all x=-16 -> -32.
- Row 2 adj all zero, MAX mode -> node2 outputs 0, empty_row=4'b0100; other rows unaffected.
- Hold out_ready=0 for 10 cycles in DONE, toggling x_flat and in_valid -> agg_flat stable, in_ready=0. Release -> out_valid drops; in_ready=1 next cycle.
- Assert rst_n low during ACCUM at j=2 -> all outputs 0 and in_ready=1 on release. A new bundle then yields correct results with no residue from the aborted bundle.
